serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Multi-cycle wide adder controller. It computes a WIDTH-bit sum by stepping one SLICE-bit ripple slice over the operands, one slice per clock, least-significant slice first.
- It trades latency for area where a full-width combinational adder is too large or too slow, e.g. DSP accumulators and address/offset arithmetic.
- It owns the sequencing FSM, the carry register, the operand/result registers and a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32: operand and sum width in bits. Must be an integer multiple of SLICE.
- SLICE, 4: bits added per clock by the slice adder.
- NSLICE, WIDTH/SLICE: derived local constant. Number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands and cin are valid.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high: rst, sampled on the rising clk edge.
- While rst is high: state=IDLE, in_ready=0, out_valid=0, busy=0, sum=0, cout=0, slice index=0, carry register=0. After the first clock with rst low, in_ready=1.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid && in_ready: capture a and b into operand shift registers, load the carry register with cin, set index=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: add operand bits [SLICE-1:0] plus the carry register through the slice adder. Shift the SLICE-bit result into the top of the working sum register (right shift). Shift the operand registers right by SLICE. Update the carry register with the slice carry-out. Increment index.
  - On the edge that processes index==NSLICE-1: copy the working sum into the sum output register, copy the final carry into cout, go to DONE.
- DONE:
  - out_valid=1. sum and cout are held stable. in_valid is ignored.
  - On an edge with out_ready=1: go to IDLE. out_valid is low from the next cycle.
- Latency: accept at edge E0 gives out_valid=1 after edge E_NSLICE, i.e. NSLICE cycles.
- Throughput: the minimum period is NSLICE+2 cycles. DONE lasts at least one cycle, and IDLE lasts at least one cycle before the next accept.
- Output holding: sum and cout change only on the completion edge. Between results they hold the last result and never show partial values.
- Arithmetic: unsigned, wraps modulo 2^WIDTH. Overflow is reported only via cout. There is no saturation.
- Backpressure: DONE holds for any number of cycles while out_ready=0. The held result stays bit-stable.
- Reset mid-operation (RUN or DONE): the operation is aborted, all outputs take their reset values, and no out_valid is produced for the aborted request.
- in_valid asserted while not IDLE: no capture. The requester must hold its data until in_ready=1.
- out_ready asserted outside DONE: no effect.

Decomposition:
- Shared package (dsp_pkg):
  - state enum: IDLE, RUN, DONE.
  - default constants: WIDTH_DEF=32, SLICE_DEF=4.
  - clog2 function for sizing the index counter (clog2(NSLICE), minimum 1 bit).
- One sub-module, slice_adder:
  - Parameter: SLICE.
  - Ports: a_s[SLICE], b_s[SLICE], c_in → s[SLICE], c_out.
  - Purely combinational ripple chain, instantiated once.
- The controller holds the FSM, counter and registers.
- Static check: elaboration fails if WIDTH % SLICE != 0.

Test Plan:
- a=0xFFFFFFFF, b=0x00000001, cin=0 → after 8 cycles out_valid=1, sum=0x00000000, cout=1.
- a=0x12345678, b=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0. in_ready=0 and busy=1 for the whole RUN and DONE.
- Backpressure: after completion, hold out_ready=0 for 5 cycles with in_valid=1 and a new operand pair applied → out_valid, sum and cout stay stable; no capture occurs. Then set out_ready=1 → IDLE next cycle, new operands accepted one cycle later.
- Reset during RUN: assert rst for one cycle at index=3 → next cycle state=IDLE, sum=0, cout=0, out_valid=0. No out_valid appears in the following 10 cycles unless a new request is made.
- Back-to-back: in_valid and out_ready held high with three operand pairs → accepts spaced exactly NSLICE+2=10 cycles apart, results in order and correct.
- WIDTH=8, SLICE=4: a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, latency 2 cycles. Also a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0, which checks the inter-slice carry.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types and constants for the serial adder controller.
// Holds the FSM state encoding, default geometry and the counter sizing helper.
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 4;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Purely combinational SLICE-bit ripple-carry adder.
// The controller steps this single slice across the full operand width.
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out
);

  logic [SLICE:0] c;

  assign c[0] = c_in;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign s[gi]   = a_s[gi] ^ b_s[gi] ^ c[gi];
    assign c[gi+1] = (a_s[gi] & b_s[gi]) | (c[gi] & (a_s[gi] ^ b_s[gi]));
  end

  assign c_out = c[SLICE];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle wide adder: one SLICE-bit slice per clock, LSB slice first.
// Valid/ready on both sides; the published sum only changes on the completion edge.
module serial_adder_ctrl
  import dsp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = clog2(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_geometry
    $error("serial_adder_ctrl: WIDTH must be a multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ready_q, ready_d;

  logic [SLICE-1:0]       sl_sum;
  logic                   sl_cout;
  logic [WIDTH+SLICE-1:0] work_cat;
  logic [WIDTH-1:0]       work_shift;

  slice_adder #(
    .SLICE (SLICE)
  ) u_slice (
    .a_s   (opa_q[SLICE-1:0]),
    .b_s   (opb_q[SLICE-1:0]),
    .c_in  (carry_q),
    .s     (sl_sum),
    .c_out (sl_cout)
  );

  // New slice enters at the top; after NSLICE steps the LSB slice sits at bit 0.
  assign work_cat   = {sl_sum, work_q};
  assign work_shift = work_cat[WIDTH+SLICE-1:SLICE];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> SLICE;
        opb_d   = opb_q >> SLICE;
        work_d  = work_shift;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = work_shift;
          cout_d  = sl_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered so in_ready stays low through the reset cycle itself.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
